nn_job_scheduler: RTL and testbench
===================================

# nn_job_scheduler

Sequencer and round-robin arbiter that owns the `nn` forward-pass datapath. It sits in front of one `nn` instance and shares it between up to four requesters. After reset it kicks the weight load and waits for it to finish. It then accepts one input pair at a time from the requesters, pulses `nn` enable, waits the fixed pipeline latency, and captures result and flags. Each result is returned on a valid/ready response channel tagged with the requester ID.

## Interface
- DATAWIDTH, 32, width of inputs/results
- NUM_REQ, 2, number of requesters (2..4)
- FSM_LATENCY, 5, edges from `nn` sampling enable=1 until final_output is updated
- LOAD_CYCLES, 9, edges `nn` needs to load weights after the load-kick enable
- CNTW, 16, width of the job and overflow counters
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset; also drives the `nn` instance
- req_valid  in  NUM_REQ  per-requester job valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_in1  in  NUM_REQ*DATAWIDTH  packed input_1 per requester; slot i = bits [i*DATAWIDTH +: DATAWIDTH]
- req_in2  in  NUM_REQ*DATAWIDTH  packed input_2 per requester; same packing as req_in1
- nn_enable  out  1  to nn.enable, registered
- nn_input_1, nn_input_2  out  DATAWIDTH  to nn inputs, registered
- nn_final_output  in  DATAWIDTH  from nn
- nn_total_ovf, nn_total_zero  in  1  from nn
- nn_ovf_stage, nn_zero_stage  in  3  from nn
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  DATAWIDTH  captured final_output
- resp_id  out  2  index of the requester that issued the job
- resp_ovf, resp_zero  out  1  captured flags
- resp_ovf_stage, resp_zero_stage  out  3  captured stage vectors
- init_done  out  1  weights loaded, scheduler serving
- busy  out  1  a job is in flight or a response is pending
- job_count, ovf_count  out  CNTW  completed jobs / completed jobs with resp_ovf=1; both saturate at all-ones

## Operation
- States:
  - KICK (reset state)
  - LOAD_WAIT
  - IDLE
  - ISSUE
  - RUN
  - RESP
- KICK: at the first edge with resetn high, set nn_enable<=1 and go to LOAD_WAIT.
- LOAD_WAIT: clear nn_enable at the next edge. Hold for LOAD_CYCLES+2 edges total, then go to IDLE and set init_done<=1.
- Reset values:
  - all outputs 0 except req_ready, which is combinational and 0 in reset;
  - round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- IDLE arbitration:
  - The grant goes to the first requester with req_valid set, searching upward from pointer+1 with wrap-around.
  - req_ready[grant] = 1 combinationally in IDLE only; all other req_ready bits are 0.
  - An accept is req_valid & req_ready at an edge. On accept:
    - latch the granted requester's inputs into nn_input_1/2;
    - latch its ID and set pointer = grant;
    - set nn_enable<=1 and go to ISSUE.
- ISSUE: lasts one cycle. nn_enable<=0, load the latency counter, go to RUN.
- RUN: nn_input_1/2 stay stable. After FSM_LATENCY+1 edges (counting from the edge where `nn` samples enable=1):
  - capture nn outputs into the resp_* registers;
  - set resp_valid<=1, increment job_count, and increment ovf_count if nn_total_ovf=1;
  - go to RESP.
- RESP: hold all resp_* outputs stable until resp_valid & resp_ready, then clear resp_valid and go to IDLE.
- Only one job is outstanding at a time; no job is accepted while in RESP.
- resp_data is passed through unmodified; `nn` already returns all-ones on overflow.
- Requesters must hold req_valid and data until accepted. Deasserting req_valid before acceptance is legal and simply removes that requester from arbitration.
- req_valid arriving before init_done is stalled (req_ready=0).
- busy = state in {ISSUE, RUN, RESP}.
- Asynchronous reset at any point: immediately return to KICK with all outputs at reset values. Any in-flight job or pending response is dropped, and the weights are reloaded.

## Timing
- Reset release: nn_enable is high for exactly one cycle after edge 1; init_done rises after edge LOAD_CYCLES+4 (edge 13 at defaults).
- Accept at edge A:
  - nn_enable is high between edges A and A+1, so `nn` samples it at A+1;
  - resp_valid rises after edge A+FSM_LATENCY+2 (A+7 at defaults).
- With resp_ready held at 1:
  - the response is consumed at A+8 and IDLE is re-entered after A+8;
  - the next accept can occur at edge A+9, giving a job period of 9 cycles.
- With all requesters valid continuously, grants rotate 0,1,…,NUM_REQ-1,0.
- Simultaneous resp_ready and new req_valid: the new job is not accepted until the edge after the response handshake.

## Test plan
- Reset release, no requests → nn_enable is a single 1-cycle pulse after edge 1; init_done=1 after edge 13; req_ready=0 throughout.
- Requester 0 sends in1=16, in2=32 with resp_ready=1 → accept at A; resp_valid after A+7; resp_data equals nn_model(16,32); resp_id=0; job_count=1.
- Both requesters hold valid for 4 jobs → resp_id sequence 0,1,0,1; each accept is 9 cycles after the previous one.
- resp_ready=0 for 20 cycles after resp_valid → resp_* values are stable; req_ready=0; requester 1 is accepted only on the edge after resp_ready goes high.
- Inputs 0x7FFFFFFF, 0x7FFFFFFF → resp_data=0xFFFFFFFF; resp_ovf=1; ovf_count increments by 1.
- resetn pulled low during RUN → all outputs are 0 immediately; after release, the load kick repeats and no stale resp_valid appears.

Source files
------------

// File: rtl/nn_job_scheduler.sv
// nn_job_scheduler
// Shares one `nn` forward-pass datapath between up to four requesters.
// After reset it pulses nn_enable once to start the weight load and waits
// for the load to finish. It then serves one job at a time, picking the
// requester round-robin. For each job it latches the requester's inputs,
// pulses nn_enable, waits the fixed pipeline latency, and captures the
// result and flags. The result is returned on a valid/ready channel that is
// tagged with the requester ID.
//
// Ports
//   clk, resetn        clock (rising edge), asynchronous active-low reset
//   req_valid/ready    per-requester handshake; req_ready is combinational
//   req_in1/2          packed per-requester operands, slot i at [i*DW +: DW]
//   nn_enable          registered enable to nn (load kick and job start)
//   nn_input_1/2       registered operands to nn, stable while a job runs
//   nn_final_output,
//   nn_total_ovf/zero,
//   nn_ovf/zero_stage  results from nn
//   resp_*             captured result, requester id and flags
//   init_done          weights loaded, scheduler serving
//   busy               job in flight or response pending
//   job_count,
//   ovf_count          saturating completed-job / overflowed-job counters
module nn_job_scheduler #(
  parameter int DATAWIDTH   = 32,
  parameter int NUM_REQ     = 2,
  parameter int FSM_LATENCY = 5,
  parameter int LOAD_CYCLES = 9,
  parameter int CNTW        = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_in1,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_in2,
  output logic                         nn_enable,
  output logic [DATAWIDTH-1:0]         nn_input_1,
  output logic [DATAWIDTH-1:0]         nn_input_2,
  input  logic [DATAWIDTH-1:0]         nn_final_output,
  input  logic                         nn_total_ovf,
  input  logic                         nn_total_zero,
  input  logic [2:0]                   nn_ovf_stage,
  input  logic [2:0]                   nn_zero_stage,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [DATAWIDTH-1:0]         resp_data,
  output logic [1:0]                   resp_id,
  output logic                         resp_ovf,
  output logic                         resp_zero,
  output logic [2:0]                   resp_ovf_stage,
  output logic [2:0]                   resp_zero_stage,
  output logic                         init_done,
  output logic                         busy,
  output logic [CNTW-1:0]              job_count,
  output logic [CNTW-1:0]              ovf_count
);

  // One counter serves both the weight-load wait and the job latency wait.
  localparam int CW = $clog2(LOAD_CYCLES + FSM_LATENCY + 4) + 1;

  typedef enum logic [2:0] {
    KICK      = 3'd0,
    LOAD_WAIT = 3'd1,
    IDLE      = 3'd2,
    ISSUE     = 3'd3,
    RUN       = 3'd4,
    RESP      = 3'd5
  } state_t;

  state_t                 state_r, state_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic [1:0]             ptr_r;
  logic [1:0]             job_id_r;
  logic [1:0]             grant_s;
  logic                   grant_vld_s;
  logic                   accept_s;
  logic                   load_done_s;
  logic                   run_done_s;
  logic [DATAWIDTH-1:0]   sel_in1_s, sel_in2_s;

  // Round-robin search: first valid requester at or after ptr_r+1, wrapping.
  always_comb begin
    grant_s     = 2'd0;
    grant_vld_s = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!grant_vld_s && req_valid[j] && (j == ((int'(ptr_r) + i) % NUM_REQ))) begin
          grant_vld_s = 1'b1;
          grant_s     = 2'(j);
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end
  end

  // Ready goes only to the granted requester, and only while idle.
  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if ((state_r == IDLE) && grant_vld_s && (grant_s == 2'(j))) begin
        req_ready[j] = 1'b1;
      end else begin
        req_ready[j] = 1'b0;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_in1_s = '0;
    sel_in2_s = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_s == 2'(j)) begin
        sel_in1_s = req_in1[j*DATAWIDTH +: DATAWIDTH];
        sel_in2_s = req_in2[j*DATAWIDTH +: DATAWIDTH];
      end else begin
        sel_in1_s = sel_in1_s;
        sel_in2_s = sel_in2_s;
      end
    end
  end

  assign accept_s    = |(req_valid & req_ready);
  assign load_done_s = (state_r == LOAD_WAIT) && (cnt_r == CW'(LOAD_CYCLES + 2));
  assign run_done_s  = (state_r == RUN) && (cnt_r == CW'(FSM_LATENCY));

  // Next-state and wait-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      KICK: begin
        state_s = LOAD_WAIT;
        cnt_s   = {CW{1'b0}};
      end
      LOAD_WAIT: begin
        if (load_done_s) begin
          state_s = IDLE;
          cnt_s   = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      IDLE: begin
        if (accept_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        // nn samples enable at this edge; the latency count starts here.
        state_s = RUN;
        cnt_s   = {CW{1'b0}};
      end
      RUN: begin
        if (run_done_s) begin
          state_s = RESP;
          cnt_s   = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = KICK;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= KICK;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_r           <= 2'(NUM_REQ - 1);
      job_id_r        <= 2'd0;
      nn_enable       <= 1'b0;
      nn_input_1      <= '0;
      nn_input_2      <= '0;
      resp_valid      <= 1'b0;
      resp_data       <= '0;
      resp_id         <= 2'd0;
      resp_ovf        <= 1'b0;
      resp_zero       <= 1'b0;
      resp_ovf_stage  <= 3'd0;
      resp_zero_stage <= 3'd0;
      init_done       <= 1'b0;
      busy            <= 1'b0;
      job_count       <= {CNTW{1'b0}};
      ovf_count       <= {CNTW{1'b0}};
    end else begin
      // Enable is a one-cycle pulse: the load kick, then once per accepted job.
      nn_enable <= (state_r == KICK) || accept_s;
      busy      <= (state_s == ISSUE) || (state_s == RUN) || (state_s == RESP);
      if (load_done_s) begin
        init_done <= 1'b1;
      end
      if (accept_s) begin
        nn_input_1 <= sel_in1_s;
        nn_input_2 <= sel_in2_s;
        job_id_r   <= grant_s;
        ptr_r      <= grant_s;
      end
      if (run_done_s) begin
        resp_valid      <= 1'b1;
        resp_data       <= nn_final_output;
        resp_id         <= job_id_r;
        resp_ovf        <= nn_total_ovf;
        resp_zero       <= nn_total_zero;
        resp_ovf_stage  <= nn_ovf_stage;
        resp_zero_stage <= nn_zero_stage;
        if (job_count != {CNTW{1'b1}}) begin
          job_count <= job_count + CNTW'(1);
        end
        if (nn_total_ovf && (ovf_count != {CNTW{1'b1}})) begin
          ovf_count <= ovf_count + CNTW'(1);
        end
      end else if ((state_r == RESP) && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nn_job_scheduler.sv
// Directed bench for nn_job_scheduler with a small behavioural nn model:
// result = a*b, or all-ones when the 64-bit product exceeds 32 bits.
module tb_nn_job_scheduler;

  localparam int DW = 32;
  localparam int NR = 2;
  localparam int LAT = 5;

  logic           clk;
  logic           resetn;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR*DW-1:0] req_in1, req_in2;
  logic           nn_enable;
  logic [DW-1:0]  nn_input_1, nn_input_2;
  logic [DW-1:0]  nn_final_output;
  logic           nn_total_ovf, nn_total_zero;
  logic [2:0]     nn_ovf_stage, nn_zero_stage;
  logic           resp_valid, resp_ready;
  logic [DW-1:0]  resp_data;
  logic [1:0]     resp_id;
  logic           resp_ovf, resp_zero;
  logic [2:0]     resp_ovf_stage, resp_zero_stage;
  logic           init_done, busy;
  logic [15:0]    job_count, ovf_count;

  nn_job_scheduler dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .nn_enable(nn_enable), .nn_input_1(nn_input_1), .nn_input_2(nn_input_2),
    .nn_final_output(nn_final_output), .nn_total_ovf(nn_total_ovf),
    .nn_total_zero(nn_total_zero), .nn_ovf_stage(nn_ovf_stage),
    .nn_zero_stage(nn_zero_stage),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .resp_ovf(resp_ovf), .resp_zero(resp_zero),
    .resp_ovf_stage(resp_ovf_stage), .resp_zero_stage(resp_zero_stage),
    .init_done(init_done), .busy(busy),
    .job_count(job_count), .ovf_count(ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // nn model: samples enable and operands, updates outputs LAT edges later.
  logic [DW-1:0] nn_a, nn_b;
  int            nn_lat;
  logic [63:0]   prod_w;
  logic          povf_w;
  assign prod_w = {32'd0, nn_a} * {32'd0, nn_b};
  assign povf_w = |prod_w[63:32];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      nn_a <= '0; nn_b <= '0; nn_lat <= 0;
      nn_final_output <= '0; nn_total_ovf <= 1'b0; nn_total_zero <= 1'b0;
      nn_ovf_stage <= 3'd0; nn_zero_stage <= 3'd0;
    end else begin
      if (nn_lat != 0) begin
        nn_lat <= nn_lat - 1;
        if (nn_lat == 1) begin
          nn_final_output <= povf_w ? 32'hFFFF_FFFF : prod_w[31:0];
          nn_total_ovf    <= povf_w;
          nn_total_zero   <= !povf_w && (prod_w[31:0] == 32'd0);
          nn_ovf_stage    <= {povf_w, 1'b0, povf_w};
          nn_zero_stage   <= {1'b0, {2{!povf_w && (prod_w[31:0] == 32'd0)}}};
        end
      end
      if (nn_enable) begin
        nn_lat <= LAT;
        nn_a   <= nn_input_1;
        nn_b   <= nn_input_2;
      end
    end
  end

  logic [143:0] all_outs;
  assign all_outs = {nn_enable, nn_input_1, nn_input_2, resp_valid, resp_data, resp_id,
                     resp_ovf, resp_zero, resp_ovf_stage, resp_zero_stage, init_done,
                     busy, job_count, ovf_count, req_ready};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Release reset at a falling edge and follow the load sequence.
  task automatic release_check(input string tag);
    int base;
    int k;
    @(negedge clk);
    resetn = 1'b1;
    base = cyc;
    for (int n = 0; n <= 15; n++) begin
      if (n > 0) @(negedge clk);
      #1;
      k = cyc - base;
      chk($sformatf("%s_load_k%0d", tag, k),
          {nn_enable, init_done, req_ready, resp_valid, busy},
          {(k == 1), (k >= 13), 2'b00, 1'b0, 1'b0});
    end
    chk({tag, "_job_count"}, job_count, 16'd0);
  endtask

  // Offer one job from requester id; return accept edge and resp_valid rise edge.
  task automatic run_job(input int id, input logic [31:0] a, input logic [31:0] b,
                         output int acc, output int rise);
    int n;
    acc = -1;
    rise = -1;
    req_in1[id*DW +: DW] = a;
    req_in2[id*DW +: DW] = b;
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (acc < 0 && n < 40) begin
      if (req_valid[id] && req_ready[id]) acc = cyc + 1;
      else begin
        @(negedge clk); #1; n++;
      end
    end
    chk("accept_seen", (acc >= 0), 1'b1);
    @(negedge clk);
    req_valid[id] = 1'b0;
    n = 0;
    while (rise < 0 && n < 40) begin
      @(negedge clk); #1; n++;
      if (resp_valid) rise = cyc;
    end
    chk("resp_seen", (rise >= 0), 1'b1);
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_ovf;
    logic        exp_zero;
    logic [2:0]  exp_os;
    logic [2:0]  exp_zs;
  } vec_t;

  vec_t vecs[6];
  int acc, rise, c, n, nacc, nresp, exp_jobs, exp_ovfs;
  int acc_e[4], acc_id[4], rid[4];

  initial begin
    resetn = 1'b0; req_valid = '0; req_in1 = '0; req_in2 = '0; resp_ready = 1'b0;
    vecs[0] = '{0, 32'd16,         32'd32,         32'd512,        1'b0, 1'b0, 3'b000, 3'b000};
    vecs[1] = '{1, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b0, 3'b101, 3'b000};
    vecs[2] = '{0, 32'd0,          32'd5,          32'd0,          1'b0, 1'b1, 3'b000, 3'b011};
    vecs[3] = '{1, 32'd3,          32'd7,          32'd21,         1'b0, 1'b0, 3'b000, 3'b000};
    vecs[4] = '{0, 32'h0001_0000,  32'h0001_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, 3'b101, 3'b000};
    vecs[5] = '{1, 32'h0000_FFFF,  32'h0000_FFFF,  32'hFFFE_0001,  1'b0, 1'b0, 3'b000, 3'b000};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", all_outs, 144'd0);
    release_check("init");

    // Single jobs from the vector table, response consumed immediately.
    resp_ready = 1'b1;
    exp_jobs = 0;
    exp_ovfs = 0;
    for (int v = 0; v < 6; v++) begin
      run_job(vecs[v].id, vecs[v].a, vecs[v].b, acc, rise);
      exp_jobs++;
      if (vecs[v].exp_ovf) exp_ovfs++;
      chk($sformatf("v%0d_latency", v), rise - acc, 7);
      chk($sformatf("v%0d_data", v), resp_data, vecs[v].exp_data);
      chk($sformatf("v%0d_id", v), resp_id, 2'(vecs[v].id));
      chk($sformatf("v%0d_flags", v), {resp_ovf, resp_zero, resp_ovf_stage, resp_zero_stage},
          {vecs[v].exp_ovf, vecs[v].exp_zero, vecs[v].exp_os, vecs[v].exp_zs});
      chk($sformatf("v%0d_busy", v), busy, 1'b1);
      chk($sformatf("v%0d_counts", v), {job_count, ovf_count}, {16'(exp_jobs), 16'(exp_ovfs)});
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_consumed", v), {resp_valid, busy}, 2'b00);
    end

    // Both requesters valid: grants alternate, one job every 9 cycles.
    req_in1 = {32'd3, 32'd2};
    req_in2 = {32'd3, 32'd2};
    req_valid = 2'b11;
    nacc = 0;
    nresp = 0;
    for (int k = 0; k < 80 && nresp < 4; k++) begin
      #1;
      if (nacc == 4 && cyc >= acc_e[3]) req_valid = 2'b00;
      #1;
      if (nacc < 4 && |(req_valid & req_ready)) begin
        acc_e[nacc] = cyc + 1;
        acc_id[nacc] = req_ready[1] ? 1 : 0;
        nacc++;
      end
      if (resp_valid && nresp < 4) begin
        rid[nresp] = int'(resp_id);
        nresp++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    chk("rr_accepts", nacc, 4);
    chk("rr_resps", nresp, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_grant%0d", k), acc_id[k], k % 2);
      chk($sformatf("rr_resp_id%0d", k), rid[k], k % 2);
    end
    for (int k = 1; k < 4; k++) chk($sformatf("rr_period%0d", k), acc_e[k] - acc_e[k-1], 9);

    // Backpressure: response held, waiting requester accepted only after handshake.
    resp_ready = 1'b0;
    run_job(0, 32'd3, 32'd7, acc, rise);
    chk("bp_data", resp_data, 32'd21);
    req_in1[DW +: DW] = 32'd5;
    req_in2[DW +: DW] = 32'd6;
    req_valid[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp_hold%0d", k), {resp_valid, resp_data, resp_id, req_ready},
          {1'b1, 32'd21, 2'd0, 2'b00});
    end
    resp_ready = 1'b1;
    #1;
    c = cyc;
    chk("bp_ready_in_resp", req_ready, 2'b00);
    @(negedge clk);
    #1;
    chk("bp_after_hs", {resp_valid, req_ready}, {1'b0, 2'b10});
    run_job(1, 32'd5, 32'd6, acc, rise);
    chk("bp_accept_edge", acc, c + 2);
    chk("bp2_data_id", {resp_data, resp_id}, {32'd30, 2'd1});
    @(negedge clk);

    // Reset while a job is running.
    req_in1[0 +: DW] = 32'd9;
    req_in2[0 +: DW] = 32'd9;
    req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!(req_valid[0] && req_ready[0]) && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk("rst_accept_seen", req_ready[0], 1'b1);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy_before", busy, 1'b1);
    resetn = 1'b0;
    #1;
    chk("rst_all_zero", all_outs, 144'd0);
    repeat (2) @(negedge clk);
    release_check("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
